// File: rtl/nibble_serializer_if.sv
// Handshake bundle for the byte-to-nibble serializer.
// The slave view belongs to the serializer. The master view belongs to whatever drives it.
interface nibble_serializer_if #(
  parameter int CNT_W = 8
);
  // byte side
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  // nibble side
  logic [3:0]       out_nibble;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  // completed-byte counter
  logic [CNT_W-1:0] byte_cnt;

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_nibble, out_valid, out_last, byte_cnt
  );

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_nibble, out_valid, out_last, byte_cnt
  );
endinterface

// File: rtl/nibble_serializer.sv
// Byte-to-nibble serializer. Each accepted byte is emitted as two nibbles.
// The nibble order is selectable.
// A new byte may be taken while the second nibble drains, so a stream runs at one nibble per clock.
module nibble_serializer #(
  parameter bit LOW_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input logic               clk,
  input logic               rst_n,
  nibble_serializer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  // Registered view of the nibble port. It is kept in one struct so that all fields update together.
  typedef struct packed {
    logic       valid;
    logic       last;
    logic [3:0] nibble;
  } out_t;

  state_t           state;
  logic [7:0]       hold_q;
  logic [CNT_W-1:0] cnt_q;
  out_t             out_q;

  logic             rdy;
  logic             in_xfer;
  logic             out_xfer;

  function automatic logic [3:0] first_nib(input logic [7:0] b);
    return LOW_FIRST ? b[3:0] : b[7:4];
  endfunction

  function automatic logic [3:0] second_nib(input logic [7:0] b);
    return LOW_FIRST ? b[7:4] : b[3:0];
  endfunction

  // The ready signal is decoded only from state and out_ready.
  // It never depends on in_valid.
  // In SECOND, a byte may be taken only if the last nibble leaves on the same edge.
  always_comb begin
    rdy      = (state == IDLE) || ((state == SECOND) && bus.out_ready);
    in_xfer  = bus.in_valid && rdy;
    out_xfer = out_q.valid && bus.out_ready;
  end

  // Single FSM process. It updates state, the holding byte, the counter and the registered outputs.
  // Reset overrides any transfer that is offered on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold_q       <= 8'h00;
      cnt_q        <= '0;
      out_q.valid  <= 1'b0;
      out_q.last   <= 1'b0;
      out_q.nibble <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_xfer) begin
            hold_q       <= bus.in_byte;
            state        <= FIRST;
            out_q.valid  <= 1'b1;
            out_q.last   <= 1'b0;
            out_q.nibble <= first_nib(bus.in_byte);
          end
        end
        FIRST: begin
          if (out_xfer) begin
            state        <= SECOND;
            out_q.last   <= 1'b1;
            out_q.nibble <= second_nib(hold_q);
          end
        end
        SECOND: begin
          if (out_xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (in_xfer) begin
              // back-to-back byte: go straight to its first nibble, no bubble
              hold_q       <= bus.in_byte;
              state        <= FIRST;
              out_q.last   <= 1'b0;
              out_q.nibble <= first_nib(bus.in_byte);
            end else begin
              state        <= IDLE;
              out_q.valid  <= 1'b0;
              out_q.last   <= 1'b0;
              out_q.nibble <= 4'h0;
            end
          end
        end
        default: begin
          state        <= IDLE;
          out_q.valid  <= 1'b0;
          out_q.last   <= 1'b0;
          out_q.nibble <= 4'h0;
        end
      endcase
    end
  end

  assign bus.in_ready   = rdy;
  assign bus.out_valid  = out_q.valid;
  assign bus.out_last   = out_q.last;
  assign bus.out_nibble = out_q.nibble;
  assign bus.byte_cnt   = cnt_q;

endmodule
